// File: rtl/ci_master_sequencer.sv
// Custom-instruction initiator: queues {ciN, valueA, valueB} commands, issues them one at a
// time to a CI slave, and returns results (or timeout markers) in order through a response FIFO.
module ci_master_sequencer #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [7:0]  i_cmd_ciN,
    input  logic [31:0] i_cmd_valueA,
    input  logic [31:0] i_cmd_valueB,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_result,
    output logic        o_rsp_timeout,
    output logic        o_ci_start,
    output logic [7:0]  o_ci_ciN,
    output logic [31:0] o_ci_valueA,
    output logic [31:0] o_ci_valueB,
    input  logic [31:0] i_ci_result,
    input  logic        i_ci_done,
    output logic        o_busy,
    output logic        o_error_sticky,
    input  logic        i_clear_error
);

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0]  CNT_ONE = 1;
    localparam logic [CAW:0]   CMD_INC = 1;
    localparam logic [RAW:0]   RSP_INC = 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t        r_state, w_next;
    logic [71:0]   r_cmd_mem [CMD_DEPTH];
    logic [CAW:0]  r_cmd_wr, r_cmd_rd;
    logic [32:0]   r_rsp_mem [RSP_DEPTH];
    logic [RAW:0]  r_rsp_wr, r_rsp_rd;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_ci_ciN;
    logic [31:0]   r_ci_valueA, r_ci_valueB;
    logic          r_error;

    logic        w_cmd_empty, w_cmd_full, w_cmd_push, w_cmd_pop;
    logic        w_rsp_empty, w_rsp_full, w_rsp_push, w_rsp_pop;
    logic        w_can_issue, w_to_hit, w_set_err;
    logic [32:0] w_rsp_data;
    logic [71:0] w_cmd_head;
    logic [32:0] w_rsp_head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_cmd_empty = (r_cmd_wr == r_cmd_rd);
    assign w_cmd_full  = (r_cmd_wr[CAW] != r_cmd_rd[CAW]) && (r_cmd_wr[CAW-1:0] == r_cmd_rd[CAW-1:0]);
    assign w_rsp_empty = (r_rsp_wr == r_rsp_rd);
    assign w_rsp_full  = (r_rsp_wr[RAW] != r_rsp_rd[RAW]) && (r_rsp_wr[RAW-1:0] == r_rsp_rd[RAW-1:0]);

    assign w_cmd_push  = i_cmd_valid & ~w_cmd_full;
    assign w_rsp_pop   = i_rsp_ready & ~w_rsp_empty;
    assign w_cmd_head  = r_cmd_mem[r_cmd_rd[CAW-1:0]];
    assign w_rsp_head  = r_rsp_mem[r_rsp_rd[RAW-1:0]];

    // Reserving a response slot before issue means the response push can never block.
    assign w_can_issue = ~w_cmd_empty & ~w_rsp_full;
    assign w_to_hit    = (TIMEOUT != 0) && (r_cnt == TO_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_can_issue) w_next = S_ISSUE;
            S_ISSUE: w_next = i_ci_done ? S_IDLE : S_WAIT;
            S_WAIT:  if (i_ci_done || w_to_hit) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_cmd_pop  = 1'b0;
        w_rsp_push = 1'b0;
        w_set_err  = 1'b0;
        o_ci_start = 1'b0;
        o_busy     = 1'b0;
        w_rsp_data = {i_ci_result, 1'b0};
        case (r_state)
            S_IDLE:  w_cmd_pop = w_can_issue;
            S_ISSUE: begin
                o_ci_start = 1'b1;
                o_busy     = 1'b1;
                w_rsp_push = i_ci_done;
            end
            S_WAIT: begin
                o_busy = 1'b1;
                if (i_ci_done) begin
                    w_rsp_push = 1'b1;
                end else if (w_to_hit) begin
                    w_rsp_push = 1'b1;
                    w_set_err  = 1'b1;
                    w_rsp_data = {32'h0, 1'b1};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_cmd_push) r_cmd_mem[r_cmd_wr[CAW-1:0]] <= {i_cmd_ciN, i_cmd_valueA, i_cmd_valueB};
        if (w_rsp_push) r_rsp_mem[r_rsp_wr[RAW-1:0]] <= w_rsp_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd_wr    <= '0;
            r_cmd_rd    <= '0;
            r_rsp_wr    <= '0;
            r_rsp_rd    <= '0;
            r_cnt       <= '0;
            r_ci_ciN    <= '0;
            r_ci_valueA <= '0;
            r_ci_valueB <= '0;
            r_error     <= 1'b0;
        end else begin
            if (w_cmd_push) r_cmd_wr <= r_cmd_wr + CMD_INC;
            if (w_cmd_pop) begin
                r_cmd_rd    <= r_cmd_rd + CMD_INC;
                r_ci_ciN    <= w_cmd_head[71:64];
                r_ci_valueA <= w_cmd_head[63:32];
                r_ci_valueB <= w_cmd_head[31:0];
            end
            if (w_rsp_push) r_rsp_wr <= r_rsp_wr + RSP_INC;
            if (w_rsp_pop)  r_rsp_rd <= r_rsp_rd + RSP_INC;
            if (r_state == S_ISSUE)     r_cnt <= '0;
            else if (r_state == S_WAIT) r_cnt <= r_cnt + CNT_ONE;
            if (w_set_err)          r_error <= 1'b1;
            else if (i_clear_error) r_error <= 1'b0;
        end
    end

    assign o_cmd_ready    = ~w_cmd_full;
    assign o_rsp_valid    = ~w_rsp_empty;
    assign o_rsp_result   = w_rsp_empty ? 32'h0 : w_rsp_head[32:1];
    assign o_rsp_timeout  = ~w_rsp_empty & w_rsp_head[0];
    assign o_ci_ciN       = r_ci_ciN;
    assign o_ci_valueA    = r_ci_valueA;
    assign o_ci_valueB    = r_ci_valueB;
    assign o_error_sticky = r_error;

endmodule

// File: tb/tb_ci_master_sequencer.sv
// Bench for ci_master_sequencer: scripted slave, table of single transactions, corner-case
// sequences, and a randomized run checked against an in-order response queue model.
module tb_ci_master_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_cmd_valid, o_cmd_ready;
    logic [7:0]  i_cmd_ciN;
    logic [31:0] i_cmd_valueA, i_cmd_valueB;
    logic        o_rsp_valid, i_rsp_ready;
    logic [31:0] o_rsp_result;
    logic        o_rsp_timeout, o_ci_start;
    logic [7:0]  o_ci_ciN;
    logic [31:0] o_ci_valueA, o_ci_valueB;
    logic [31:0] ci_result;
    logic        ci_done, o_busy, o_error_sticky, i_clear_error;

    always #5 clk = ~clk;

    ci_master_sequencer #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_ciN(i_cmd_ciN),
        .i_cmd_valueA(i_cmd_valueA), .i_cmd_valueB(i_cmd_valueB),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_result(o_rsp_result), .o_rsp_timeout(o_rsp_timeout),
        .o_ci_start(o_ci_start), .o_ci_ciN(o_ci_ciN), .o_ci_valueA(o_ci_valueA),
        .o_ci_valueB(o_ci_valueB), .i_ci_result(ci_result), .i_ci_done(ci_done),
        .o_busy(o_busy), .o_error_sticky(o_error_sticky), .i_clear_error(i_clear_error)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave behaviour: latency = ciN[4:0] cycles after the start cycle; ciN==0 acts as a RAM
    // (valueA[8]=write, valueA[7:0]=address, valueB=write data); others return A^B^ciN.
    function automatic logic [31:0] fn(input logic [7:0] n, input logic [31:0] a, input logic [31:0] b);
        return a ^ b ^ {24'h0, n};
    endfunction

    function automatic int lat_of(input logic [7:0] n);
        return int'(n[4:0]);
    endfunction

    logic        slave_en, manual_done, pend;
    int          cnt;
    logic [31:0] ram [256];

    initial begin
        ci_done = 1'b0; ci_result = '0; pend = 1'b0; cnt = 0;
        for (int i = 0; i < 256; i++) ram[i] = '0;
        forever begin
            @(posedge clk); #2;
            ci_done = 1'b0; ci_result = '0;
            if (!rst_n || !o_busy) pend = 1'b0;
            if (manual_done) begin
                ci_done = 1'b1; ci_result = 32'hBAD0_0BAD;
            end else if (slave_en && rst_n) begin
                if (o_ci_start) begin pend = 1'b1; cnt = lat_of(o_ci_ciN); end
                if (pend) begin
                    if (cnt == 0) begin
                        ci_done = 1'b1; pend = 1'b0;
                        if (o_ci_ciN == 8'h0) begin
                            if (o_ci_valueA[8]) ram[o_ci_valueA[7:0]] = o_ci_valueB;
                            else                ci_result = ram[o_ci_valueA[7:0]];
                        end else begin
                            ci_result = fn(o_ci_ciN, o_ci_valueA, o_ci_valueB);
                        end
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic clear_err();
        i_clear_error = 1'b1; cycle(); i_clear_error = 1'b0;
    endtask

    // One command from idle; observes 40 cycles with rsp_ready=1.
    task automatic run_one(input logic [7:0] n, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic to, output int busy_n,
                           output int start_n, output int start_k, output logic got);
        i_cmd_valid = 1'b1; i_cmd_ciN = n; i_cmd_valueA = a; i_cmd_valueB = b; i_rsp_ready = 1'b1;
        cycle();
        i_cmd_valid = 1'b0;
        got = 1'b0; busy_n = 0; start_n = 0; start_k = -1; res = '0; to = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (o_busy) busy_n++;
            if (o_ci_start) begin
                start_n++;
                if (start_k < 0) start_k = k;
                chk("start_operands", {o_ci_ciN, o_ci_valueA, o_ci_valueB}, {n, a, b});
            end
            if (o_rsp_valid && !got) begin got = 1'b1; res = o_rsp_result; to = o_rsp_timeout; end
            cycle();
        end
    endtask

    typedef struct {
        logic [7:0]  ci;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        to;
        int          busy;
    } vec_t;

    vec_t        tbl [7];
    logic [31:0] r_res;
    logic        r_to, r_got, bad, prev_start, saw_to, seen_busy;
    int          r_busy, r_start, r_k, starts, n;
    logic [32:0] exp_q [$];
    logic [32:0] e;
    logic [31:0] t4_a [8];

    initial begin
        tbl[0] = '{8'h20, 32'h0000_00FF, 32'h0000_0F00, 32'h0000_0FDF, 1'b0, 1};
        tbl[1] = '{8'h03, 32'h1234_5678, 32'h0000_0000, 32'h1234_567B, 1'b0, 4};
        tbl[2] = '{8'h10, 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_FFEF, 1'b0, 17};
        tbl[3] = '{8'h11, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1'b1, 17};
        tbl[4] = '{8'h1F, 32'h0BAD_F00D, 32'h0000_0001, 32'h0000_0000, 1'b1, 17};
        tbl[5] = '{8'h01, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFE, 1'b0, 2};
        tbl[6] = '{8'hE0, 32'h8000_0001, 32'h0000_0001, 32'h8000_00E0, 1'b0, 1};

        rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_ciN = '0; i_cmd_valueA = '0; i_cmd_valueB = '0;
        i_rsp_ready = 1'b0; i_clear_error = 1'b0; slave_en = 1'b1; manual_done = 1'b0;
        #12;
        chk("rst_cmd_ready", o_cmd_ready, 1);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_rsp_data", {o_rsp_result, o_rsp_timeout}, 0);
        chk("rst_start_busy", {o_ci_start, o_busy}, 0);
        chk("rst_err", o_error_sticky, 0);
        chk("rst_ci_regs", {o_ci_ciN, o_ci_valueA, o_ci_valueB}, 0);
        rst_n = 1'b1;
        cycle();

        // RAM slave write then read-back
        run_one(8'h00, 32'h105, 32'hDEAD_BEEF, r_res, r_to, r_busy, r_start, r_k, r_got);
        chk("ram_wr_got", r_got, 1);
        run_one(8'h00, 32'h005, 32'h0, r_res, r_to, r_busy, r_start, r_k, r_got);
        chk("ram_rd_got", r_got, 1);
        chk("ram_rd_result", r_res, 32'hDEAD_BEEF);
        chk("ram_rd_timeout", r_to, 0);

        foreach (tbl[i]) begin
            clear_err();
            run_one(tbl[i].ci, tbl[i].a, tbl[i].b, r_res, r_to, r_busy, r_start, r_k, r_got);
            chk($sformatf("tbl%0d_got", i), r_got, 1);
            chk($sformatf("tbl%0d_result", i), r_res, tbl[i].res);
            chk($sformatf("tbl%0d_timeout", i), r_to, tbl[i].to);
            chk($sformatf("tbl%0d_busy_cycles", i), r_busy, tbl[i].busy);
            chk($sformatf("tbl%0d_start_pulses", i), r_start, 1);
            chk($sformatf("tbl%0d_start_latency", i), r_k, 1);
            chk($sformatf("tbl%0d_err", i), o_error_sticky, tbl[i].to);
        end

        // Dead slave: timeout after 16 WAIT cycles, then clear, then clear racing a timeout
        slave_en = 1'b0;
        clear_err();
        run_one(8'h05, 32'h7, 32'h9, r_res, r_to, r_busy, r_start, r_k, r_got);
        chk("to_rsp", {r_got, r_res, r_to}, {1'b1, 32'h0, 1'b1});
        chk("to_busy_cycles", r_busy, 17);
        chk("to_err_set", o_error_sticky, 1);
        clear_err();
        chk("to_err_cleared", o_error_sticky, 0);
        i_cmd_valid = 1'b1; i_cmd_ciN = 8'h05; cycle(); i_cmd_valid = 1'b0;
        i_clear_error = 1'b1; seen_busy = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (seen_busy && !o_busy) break;
            if (o_busy) seen_busy = 1'b1;
            cycle();
        end
        i_clear_error = 1'b0;
        chk("simul_err_stays", o_error_sticky, 1);
        chk("simul_rsp", {o_rsp_valid, o_rsp_timeout}, 2'b11);
        cycle();
        clear_err();
        slave_en = 1'b1;

        // Back-pressure: response FIFO full blocks issue, command FIFO then fills
        i_rsp_ready = 1'b0; starts = 0;
        for (int i = 0; i < 8; i++) t4_a[i] = 32'h1000_0000 + i;
        for (int i = 0; i < 6; i++) begin
            if (o_ci_start) starts++;
            i_cmd_valid = 1'b1; i_cmd_ciN = 8'h40; i_cmd_valueA = t4_a[i]; i_cmd_valueB = i;
            cycle();
        end
        i_cmd_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin if (o_ci_start) starts++; cycle(); end
        chk("bp_starts", starts, 4);
        chk("bp_cmd_ready_mid", o_cmd_ready, 1);
        for (int i = 6; i < 8; i++) begin
            i_cmd_valid = 1'b1; i_cmd_ciN = 8'h40; i_cmd_valueA = t4_a[i]; i_cmd_valueB = i;
            cycle();
        end
        chk("bp_cmd_full", o_cmd_ready, 0);
        i_cmd_valueA = 32'h5555_5555; cycle();
        i_cmd_valid = 1'b0;
        chk("bp_idle_blocked", {o_busy, o_ci_start}, 0);
        i_rsp_ready = 1'b1; n = 0;
        for (int k = 0; k < 80; k++) begin
            if (o_ci_start) starts++;
            if (o_rsp_valid) begin
                if (n < 8) chk($sformatf("bp_rsp%0d", n), {o_rsp_result, o_rsp_timeout},
                               {fn(8'h40, t4_a[n], 32'(n)), 1'b0});
                n++;
            end
            cycle();
        end
        chk("bp_rsp_count", n, 8);
        chk("bp_total_starts", starts, 8);

        // Reset while waiting on a dead slave; late done afterwards must be ignored
        slave_en = 1'b0;
        i_cmd_valid = 1'b1; i_cmd_ciN = 8'h07; i_cmd_valueA = 32'hCAFE; cycle(); i_cmd_valid = 1'b0;
        for (int k = 0; k < 5; k++) cycle();
        chk("rstw_pre_busy", o_busy, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("rstw_async_outs", {o_ci_start, o_busy, o_rsp_valid, o_cmd_ready}, 4'b0001);
        chk("rstw_ci_regs", {o_ci_ciN, o_ci_valueA}, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        cycle();
        manual_done = 1'b1; cycle(); manual_done = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin if (o_rsp_valid || o_busy) bad = 1'b1; cycle(); end
        chk("rstw_late_done_ignored", bad, 0);

        // Stray done in idle with empty command FIFO
        manual_done = 1'b1; cycle(); manual_done = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin if (o_rsp_valid || o_busy) bad = 1'b1; cycle(); end
        chk("stray_done_ignored", bad, 0);
        slave_en = 1'b1;
        run_one(8'h02, 32'h0000_1000, 32'h0000_0001, r_res, r_to, r_busy, r_start, r_k, r_got);
        chk("after_stray_rsp", {r_got, r_res, r_to}, {1'b1, 32'h0000_1003, 1'b0});

        // Randomized traffic against an in-order expected-response queue
        clear_err();
        saw_to = 1'b0; prev_start = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            if (o_ci_start) chk("rand_start_single", prev_start, 0);
            prev_start = o_ci_start;
            i_rsp_ready = ($urandom_range(0, 3) != 0);
            if (i_rsp_ready && o_rsp_valid) begin
                if (exp_q.size() == 0) chk("rand_unexpected_rsp", 1, 0);
                else begin e = exp_q.pop_front(); chk("rand_rsp", {o_rsp_result, o_rsp_timeout}, e); end
            end
            i_cmd_valid  = ($urandom_range(0, 2) == 0);
            i_cmd_ciN    = {3'($urandom), 5'($urandom_range(0, 20))};
            if (i_cmd_ciN == 8'h0) i_cmd_ciN = 8'h01;
            i_cmd_valueA = $urandom;
            i_cmd_valueB = $urandom;
            if (i_cmd_valid && o_cmd_ready) begin
                if (lat_of(i_cmd_ciN) > TO) begin exp_q.push_back({32'h0, 1'b1}); saw_to = 1'b1; end
                else exp_q.push_back({fn(i_cmd_ciN, i_cmd_valueA, i_cmd_valueB), 1'b0});
            end
            cycle();
        end
        i_cmd_valid = 1'b0; i_rsp_ready = 1'b1;
        for (int k = 0; k < 800 && exp_q.size() > 0; k++) begin
            if (o_rsp_valid) begin e = exp_q.pop_front(); chk("drain_rsp", {o_rsp_result, o_rsp_timeout}, e); end
            cycle();
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        for (int k = 0; k < 3; k++) cycle();
        chk("drain_rsp_valid", o_rsp_valid, 0);
        chk("rand_err_sticky", o_error_sticky, saw_to);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
